// File: rtl/ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage
//   Execute stage of the MIPS pipeline. Selects forwarded operands, picks
//   operand B (forwarded rt or immediate), evaluates the ALU operation chosen
//   by the ALU control decoder and latches the result together with the
//   memory/writeback control into the EX/MEM pipeline register.
//   One cycle latency; supports stall (hold) and flush (bubble).
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_stall, i_flush          hold EX/MEM / load a bubble (flush wins)
//   i_valid                   ID/EX holds a real instruction
//   i_alucontrol[3:0]         ALU operation code
//   i_rs_data, i_rt_data      ID/EX register operands
//   i_imm                     sign-extended immediate
//   i_shamt[4:0]              shift amount field
//   i_alusrc                  0: B = forwarded rt, 1: B = immediate
//   i_fwd_a_sel, i_fwd_b_sel  00/11 register, 01 EX/MEM result, 10 MEM/WB
//   i_memwb_data              MEM/WB writeback value
//   i_write_reg               destination register index
//   i_regwrite..i_memtoreg    control from ID/EX
//   o_alu_result, o_zero      registered ALU result and A==B flag
//   o_store_data              registered forwarded rt (store data)
//   o_write_reg, o_regwrite, o_memread, o_memwrite, o_memtoreg
//                             registered destination and control
//   o_valid                   EX/MEM holds a real instruction
// ---------------------------------------------------------------------------
module ex_mem_alu_stage #(
  parameter int SIZE    = 32,
  parameter int SIZEREG = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [3:0]         i_alucontrol,
  input  logic [SIZE-1:0]    i_rs_data,
  input  logic [SIZE-1:0]    i_rt_data,
  input  logic [SIZE-1:0]    i_imm,
  input  logic [4:0]         i_shamt,
  input  logic               i_alusrc,
  input  logic [1:0]         i_fwd_a_sel,
  input  logic [1:0]         i_fwd_b_sel,
  input  logic [SIZE-1:0]    i_memwb_data,
  input  logic [SIZEREG-1:0] i_write_reg,
  input  logic               i_regwrite,
  input  logic               i_memread,
  input  logic               i_memwrite,
  input  logic               i_memtoreg,
  output logic [SIZE-1:0]    o_alu_result,
  output logic               o_zero,
  output logic [SIZE-1:0]    o_store_data,
  output logic [SIZEREG-1:0] o_write_reg,
  output logic               o_regwrite,
  output logic               o_memread,
  output logic               o_memwrite,
  output logic               o_memtoreg,
  output logic               o_valid
);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_SRA  = 4'b0010;
  localparam logic [3:0] OP_SLLV = 4'b0011;
  localparam logic [3:0] OP_SRLV = 4'b0100;
  localparam logic [3:0] OP_SRAV = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_SUBU = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1101;
  localparam logic [3:0] OP_ZERO = 4'b1110;

  logic [SIZE-1:0]    r_alu_result;
  logic               r_zero;
  logic [SIZE-1:0]    r_store_data;
  logic [SIZEREG-1:0] r_write_reg;
  logic               r_regwrite;
  logic               r_memread;
  logic               r_memwrite;
  logic               r_memtoreg;
  logic               r_valid;

  logic [SIZE-1:0]    w_a;
  logic [SIZE-1:0]    w_fwd_b;
  logic [SIZE-1:0]    w_b;
  logic [SIZE-1:0]    w_alu;

  // Operation evaluation. Code 1111 (address generation, BEQ and any
  // unrecognised decode) falls through to the default add.
  function automatic logic [SIZE-1:0] alu_eval(
    input logic [3:0]      op,
    input logic [SIZE-1:0] a,
    input logic [SIZE-1:0] b,
    input logic [4:0]      shamt
  );
    logic signed [SIZE-1:0] sa;
    logic signed [SIZE-1:0] sb;
    logic [SIZE-1:0]        res;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_SLL:  res = b << shamt;
      OP_SRL:  res = b >> shamt;
      OP_SRA:  res = sb >>> shamt;
      // Variable shifts use only the low five bits of A.
      OP_SLLV: res = b << a[4:0];
      OP_SRLV: res = b >> a[4:0];
      OP_SRAV: res = sb >>> a[4:0];
      OP_ADDU: res = a + b;
      OP_SUBU: res = a - b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_AND:  res = a & b;
      OP_NOR:  res = ~(a | b);
      OP_SLT:  res = {{(SIZE-1){1'b0}}, (sa < sb)};
      OP_LUI:  res = {{(SIZE-16){1'b0}}, b[15:0]} << 16;
      OP_ZERO: res = '0;
      default: res = a + b;
    endcase
    return res;
  endfunction

  // Forwarding muxes: 01 takes the result currently held in EX/MEM.
  always_comb begin
    w_a = i_rs_data;
    case (i_fwd_a_sel)
      2'b01:   w_a = r_alu_result;
      2'b10:   w_a = i_memwb_data;
      default: w_a = i_rs_data;
    endcase
  end

  always_comb begin
    w_fwd_b = i_rt_data;
    case (i_fwd_b_sel)
      2'b01:   w_fwd_b = r_alu_result;
      2'b10:   w_fwd_b = i_memwb_data;
      default: w_fwd_b = i_rt_data;
    endcase
  end

  assign w_b   = i_alusrc ? i_imm : w_fwd_b;
  assign w_alu = alu_eval(i_alucontrol, w_a, w_b, i_shamt);

  // EX/MEM register. Reset and flush both clear everything (data included);
  // a stall holds. A reset during a stall discards the held instruction.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_alu_result <= '0;
      r_zero       <= 1'b0;
      r_store_data <= '0;
      r_write_reg  <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_valid      <= 1'b0;
    end else if (!i_stall) begin
      r_alu_result <= w_alu;
      r_zero       <= (w_a == w_b);
      r_store_data <= w_fwd_b;
      r_write_reg  <= i_write_reg;
      // Data fields still load for an invalid slot; only control is gated.
      r_regwrite   <= i_valid & i_regwrite;
      r_memread    <= i_valid & i_memread;
      r_memwrite   <= i_valid & i_memwrite;
      r_memtoreg   <= i_valid & i_memtoreg;
      r_valid      <= i_valid;
    end
  end

  assign o_alu_result = r_alu_result;
  assign o_zero       = r_zero;
  assign o_store_data = r_store_data;
  assign o_write_reg  = r_write_reg;
  assign o_regwrite   = r_regwrite;
  assign o_memread    = r_memread;
  assign o_memwrite   = r_memwrite;
  assign o_memtoreg   = r_memtoreg;
  assign o_valid      = r_valid;

endmodule
